// File: rtl/mem6502.sv
// mem6502: 6502 system memory model.
//   - RAM of 2**RAM_AW bytes at $0000, reset vector at $FFFC/$FFFD, FILL elsewhere.
//   - CPU writes commit once per bus cycle, on the phi2 falling edge seen in the clk domain.
//   - A bench loader port shares the RAM write port. CPU writes win, and the loader is stalled.
//   - Optional trace FIFO of committed CPU writes (8 deep), enabled by defining MEM6502_TRACE_EN.
module mem6502 #(
    parameter int          RAM_AW       = 11,
    parameter logic [15:0] RESET_VECTOR = 16'h0000,
    parameter logic [7:0]  FILL         = 8'hff
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       addr,
    input  logic [7:0]        odata,
    input  logic              rw,
    input  logic              clk2,
    output logic [7:0]        idata,
    input  logic              ld_valid,
    input  logic [RAM_AW-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    output logic              tr_valid,
    output logic [15:0]       tr_addr,
    output logic [7:0]        tr_data,
    input  logic              tr_pop,
    output logic              tr_overflow
);
    localparam int RAM_SZ = 1 << RAM_AW;

    logic [7:0]        ram_q [RAM_SZ];
    logic              clk2_q;
    logic [7:0]        idata_q, idata_d;
    logic              phi2_fall, cpu_wr, ram_hit, ld_wr;
    logic              wr_en;
    logic [RAM_AW-1:0] wr_addr;
    logic [7:0]        wr_data;

    // A cleared clk2_q after reset hides a phi2 fall in the first cycle after reset.
    assign phi2_fall = clk2_q & ~clk2;
    assign cpu_wr    = phi2_fall & ~rw & ~reset;
    assign ram_hit   = (addr >> RAM_AW) == 16'd0;
    assign ld_ready  = ~reset & ~cpu_wr;
    assign ld_wr     = ld_valid & ld_ready;

    // Single RAM write port: a CPU commit to RAM, otherwise an accepted loader write.
    always_comb begin
        wr_en   = ld_wr | (cpu_wr & ram_hit);
        wr_addr = ld_addr;
        wr_data = ld_data;
        if (cpu_wr) begin
            wr_addr = addr[RAM_AW-1:0];
            wr_data = odata;
        end
    end

    // Read decode. A same-cycle write to the addressed byte is forwarded so data is never stale.
    always_comb begin
        idata_d = FILL;
        if (ram_hit) begin
            if (wr_en && wr_addr == addr[RAM_AW-1:0])
                idata_d = wr_data;
            else
                idata_d = ram_q[addr[RAM_AW-1:0]];
        end else if (addr == 16'hFFFC) begin
            idata_d = RESET_VECTOR[7:0];
        end else if (addr == 16'hFFFD) begin
            idata_d = RESET_VECTOR[15:8];
        end
    end

    // RAM storage. It has no reset, and its contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            ram_q[wr_addr] <= wr_data;
    end

    // Phase sampler and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk2_q  <= 1'b0;
            idata_q <= 8'h00;
        end else begin
            clk2_q  <= clk2;
            idata_q <= idata_d;
        end
    end

    assign idata = idata_q;

`ifdef MEM6502_TRACE_EN
    logic [23:0] fifo_q [8];
    logic [2:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        full, push_ok, pop_ok;

    // FIFO control. When the FIFO is full, a push is accepted only if a pop frees a slot in the same cycle.
    always_comb begin
        full    = cnt_q == 4'd8;
        pop_ok  = tr_pop && cnt_q != 4'd0;
        push_ok = cpu_wr && (!full || pop_ok);
        wptr_d  = push_ok ? wptr_q + 3'd1 : wptr_q;
        rptr_d  = pop_ok  ? rptr_q + 3'd1 : rptr_q;
        cnt_d   = cnt_q + {3'b000, push_ok} - {3'b000, pop_ok};
        ovf_d   = ovf_q | (cpu_wr & full & ~pop_ok);
    end

    // FIFO pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= 3'd0;
            rptr_q <= 3'd0;
            cnt_q  <= 4'd0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // FIFO entry storage. push_ok is already low during reset.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_q[wptr_q] <= {addr, odata};
    end

    assign tr_valid            = cnt_q != 4'd0;
    assign {tr_addr, tr_data}  = tr_valid ? fifo_q[rptr_q] : 24'h0;
    assign tr_overflow         = ovf_q;
`else
    logic unused_tr_pop;
    assign unused_tr_pop = tr_pop;
    assign tr_valid      = 1'b0;
    assign tr_addr       = 16'h0000;
    assign tr_data       = 8'h00;
    assign tr_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_mem6502.sv
// Directed bench for mem6502. The trace expectations adapt to MEM6502_TRACE_EN.
module tb_mem6502;
    logic        clk = 1'b0;
    logic        reset, rw, clk2, ld_valid, ld_ready, tr_valid, tr_pop, tr_overflow;
    logic [15:0] addr, tr_addr;
    logic [7:0]  odata, idata, ld_data, tr_data;
    logic [10:0] ld_addr;
    int          passed = 0, total = 0, fails = 0;

`ifdef MEM6502_TRACE_EN
    localparam bit TR = 1'b1;
`else
    localparam bit TR = 1'b0;
`endif

    always #5 clk = ~clk;

    mem6502 #(.RAM_AW(11), .RESET_VECTOR(16'hC0DE), .FILL(8'hFF)) dut (
        .clk(clk), .reset(reset), .addr(addr), .odata(odata), .rw(rw), .clk2(clk2),
        .idata(idata), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .ld_ready(ld_ready), .tr_valid(tr_valid), .tr_addr(tr_addr), .tr_data(tr_data),
        .tr_pop(tr_pop), .tr_overflow(tr_overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e, input string tag);
        addr = a; rw = 1'b1;
        step;
        chk(tag, {24'h0, idata}, {24'h0, e});
    endtask

    // One bus cycle: phi2 high for a cycle, then low. The commit happens at the edge that ends the low cycle.
    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input bit pop);
        addr = a; odata = d; rw = 1'b0; clk2 = 1'b1;
        step;
        clk2 = 1'b0; tr_pop = pop;
        step;
        tr_pop = 1'b0; rw = 1'b1;
    endtask

    task automatic pop1;
        tr_pop = 1'b1;
        step;
        tr_pop = 1'b0;
    endtask

    initial begin
        reset = 1'b1; rw = 1'b1; clk2 = 1'b0; addr = 16'h0; odata = 8'h0;
        ld_valid = 1'b0; ld_addr = 11'h0; ld_data = 8'h0; tr_pop = 1'b0;
        step; step;
        chk("rst_idata", {24'h0, idata}, 32'h0);
        chk("rst_ld_ready", {31'h0, ld_ready}, 32'h0);
        chk("rst_tr_valid", {31'h0, tr_valid}, 32'h0);
        chk("rst_ovf", {31'h0, tr_overflow}, 32'h0);
        reset = 1'b0;

        // Loader fills $0000/$0001, then reads back, checks the vectors and the unmapped fill value.
        ld_valid = 1'b1; ld_addr = 11'h000; ld_data = 8'hA9;
        #1 chk("ld_ready_idle", {31'h0, ld_ready}, 32'h1);
        step;
        ld_addr = 11'h001; ld_data = 8'h55;
        step;
        ld_valid = 1'b0;
        rd(16'h0001, 8'h55, "rd_0001");
        rd(16'h0000, 8'hA9, "rd_0000");
        rd(16'hFFFC, 8'hDE, "rd_vec_lo");
        rd(16'hFFFD, 8'hC0, "rd_vec_hi");
        rd(16'h0800, 8'hFF, "rd_unmapped_0800");

        // Single CPU write. Holding phi2 low afterwards must not commit again.
        cpu_write(16'h0099, 8'h00, 1'b0);
        chk("tr1_valid", {31'h0, tr_valid}, {31'h0, TR});
        chk("tr1_addr", {16'h0, tr_addr}, TR ? 32'h0099 : 32'h0);
        addr = 16'h0099; odata = 8'h33; rw = 1'b0; clk2 = 1'b0;
        step; step;
        rw = 1'b1;
        rd(16'h0099, 8'h00, "rd_0099");
        pop1;
        chk("tr1_once", {31'h0, tr_valid}, 32'h0);
        chk("tr_empty_addr", {16'h0, tr_addr}, 32'h0);

        // Loader collides with a CPU commit and must be stalled for one cycle, not dropped.
        addr = 16'h0020; odata = 8'h44; rw = 1'b0; clk2 = 1'b1;
        step;
        clk2 = 1'b0; ld_valid = 1'b1; ld_addr = 11'h021; ld_data = 8'h66;
        #1 chk("ld_ready_commit", {31'h0, ld_ready}, 32'h0);
        step;
        rw = 1'b1;
        chk("ld_ready_after", {31'h0, ld_ready}, 32'h1);
        step;
        ld_valid = 1'b0;
        rd(16'h0020, 8'h44, "rd_cpu_0020");
        rd(16'h0021, 8'h66, "rd_ld_0021");
        pop1;

        // Nine writes without popping: the ninth is dropped and overflow is set.
        for (int i = 0; i < 9; i++) cpu_write(16'h0010 + 16'(i), 8'h10 + 8'(i), 1'b0);
        chk("ovf_set", {31'h0, tr_overflow}, {31'h0, TR});
        for (int i = 0; i < 8; i++) begin
            chk("ovf_head_addr", {16'h0, tr_addr}, TR ? 32'h10 + 32'(i) : 32'h0);
            chk("ovf_head_data", {24'h0, tr_data}, TR ? 32'h10 + 32'(i) : 32'h0);
            pop1;
        end
        chk("ovf_drained", {31'h0, tr_valid}, 32'h0);
        chk("ovf_sticky", {31'h0, tr_overflow}, {31'h0, TR});

        // A pop while the FIFO is empty is ignored.
        pop1;
        cpu_write(16'h0050, 8'h50, 1'b0);
        chk("empty_pop_valid", {31'h0, tr_valid}, {31'h0, TR});
        chk("empty_pop_addr", {16'h0, tr_addr}, TR ? 32'h0050 : 32'h0);
        pop1;
        chk("empty_pop_drained", {31'h0, tr_valid}, 32'h0);

        // Reset clears the FIFO and overflow state but keeps the RAM contents.
        reset = 1'b1; step; reset = 1'b0;
        chk("rst2_ovf", {31'h0, tr_overflow}, 32'h0);
        rd(16'h0000, 8'hA9, "ram_kept_reset");
        for (int i = 0; i < 8; i++) cpu_write(16'h0030 + 16'(i), 8'(i), 1'b0);
        cpu_write(16'h0038, 8'h38, 1'b1);
        chk("full_pp_ovf", {31'h0, tr_overflow}, 32'h0);
        chk("full_pp_head", {16'h0, tr_addr}, TR ? 32'h0031 : 32'h0);
        for (int i = 0; i < 7; i++) pop1;
        chk("full_pp_last_addr", {16'h0, tr_addr}, TR ? 32'h0038 : 32'h0);
        chk("full_pp_last_data", {24'h0, tr_data}, TR ? 32'h38 : 32'h0);
        pop1;
        chk("full_pp_drained", {31'h0, tr_valid}, 32'h0);

        // Unmapped write: storage is untouched (including the $0000 alias), but it is still traced.
        cpu_write(16'h4000, 8'h5A, 1'b0);
        rd(16'h4000, 8'hFF, "rd_unmapped_4000");
        rd(16'h0000, 8'hA9, "no_alias_0000");
        chk("tr_unmapped_addr", {16'h0, tr_addr}, TR ? 32'h4000 : 32'h0);
        chk("tr_unmapped_data", {24'h0, tr_data}, TR ? 32'h5A : 32'h0);
        pop1;

        // Reset asserted on the commit edge suppresses the write.
        addr = 16'h0020; odata = 8'h99; rw = 1'b0; clk2 = 1'b1;
        step;
        clk2 = 1'b0; reset = 1'b1;
        step;
        reset = 1'b0; rw = 1'b1;
        chk("rst_wr_fifo", {31'h0, tr_valid}, 32'h0);
        rd(16'h0020, 8'h44, "rst_wr_ram");

        // A phi2 fall in the first cycle after reset is not seen.
        reset = 1'b1; clk2 = 1'b1; rw = 1'b0; addr = 16'h0021; odata = 8'h99;
        step;
        reset = 1'b0; clk2 = 1'b0;
        #1 chk("post_rst_no_fall", {31'h0, ld_ready}, 32'h1);
        step;
        rw = 1'b1;
        rd(16'h0021, 8'h66, "post_rst_ram");
        chk("post_rst_fifo", {31'h0, tr_valid}, 32'h0);

        // A loader request during reset is not accepted.
        reset = 1'b1; ld_valid = 1'b1; ld_addr = 11'h001; ld_data = 8'h77;
        #1 chk("rst_ld_block", {31'h0, ld_ready}, 32'h0);
        step;
        ld_valid = 1'b0; reset = 1'b0;
        rd(16'h0001, 8'h55, "rst_ld_ram");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
